flr_sequencer: RTL and testbench
================================

// Module: flr_sequencer
// PURPOSE
//  Upstream stage of the FLR responder. Tracks Function Level Reset per PF (PF0..PF3), holds that PF's user logic
//  in reset, and waits for the PF to go idle. It then gives the responder a one-cycle enable and a stable 4-bit
//  done vector, and waits for write completion. Bounded retry on timeout. Sticky errors go to the status CSR block.
// PARAMETERS
//  NUM_PF          4     PFs tracked; fixed at 4 by the FLR-done CSR layout
//  MIN_RST_CYCLES  16    minimum o_pf_reset assertion per FLR, in cycles (>=2)
//  TIMEOUT_CYCLES  1024  maximum wait for i_written_valid after o_enable
//  MAX_RETRY       3     re-issues after timeout before o_timeout_error is raised
// PORTS
//  i_clk            in   1   single clock, shared with the responder NAP
//  i_reset          in   1   reset, synchronous, active-high
//  i_flr_pf_active  in   4   level from PCIe core; bit n high = FLR in progress on PFn
//  i_pf_quiesced    in   4   PFn user logic idle, no outstanding NAP transactions
//  o_pf_reset       out  4   active-high reset to PFn user logic
//  o_enable         out  1   one-cycle pulse to responder i_enable
//  o_flr_pf_done    out  4   done vector to responder flr_pf_done; registered
//  i_written_valid  in   1   responder write complete (one-cycle pulse)
//  i_wr_error       in   1   responder sticky bresp/bid error
//  o_busy           out  1   any PF not in PF_IDLE, or write FSM not in W_IDLE
//  o_wr_error       out  1   sticky; i_wr_error was seen
//  o_timeout_error  out  1   sticky; MAX_RETRY+1 consecutive timeouts
// BEHAVIOUR
//  Reset values: all outputs 0; all PFs in PF_IDLE; write FSM in W_IDLE; counters 0; FLR edge-detect history = 0.
//  Per-PF FSM, advances 1 state per cycle at most:
//   PF_IDLE  : rising edge of i_flr_pf_active[n] -> PF_RESET; o_pf_reset[n] goes to 1 in the same cycle (registered).
//   PF_RESET : count MIN_RST_CYCLES -> PF_DRAIN.
//   PF_DRAIN : i_pf_quiesced[n]=1 -> PF_PEND.
//   PF_PEND  : included in the next write snapshot; snapshot accepted -> PF_ACK.
//   PF_ACK   : i_flr_pf_active[n]=0 -> PF_IDLE; o_pf_reset[n] goes to 0 on the same transition.
//   Abort: i_flr_pf_active[n] falls in RESET, DRAIN or PEND -> PF_IDLE next cycle; o_pf_reset released.
//   A re-assertion needs a fresh rising edge. Level high on exit from reset does not start an FLR.
//  Write FSM:
//   W_IDLE  : any PF in PF_PEND -> W_ISSUE.
//   W_ISSUE : latch o_flr_pf_done[n] = (PF_PEND|PF_ACK); pulse o_enable for 1 cycle; clear timer -> W_WAIT.
//   W_WAIT  : i_written_valid -> W_IDLE, PEND bits in the snapshot move to PF_ACK, retry count cleared.
//             Timer reaches TIMEOUT_CYCLES-1 -> retry < MAX_RETRY: retry++, go to W_ISSUE with the same snapshot;
//             otherwise set o_timeout_error, go to W_IDLE, leave PFs in PEND.
//  o_flr_pf_done is constant from W_ISSUE through the end of W_WAIT. The responder drives wdata from it
//   combinationally, so it must be stable.
//  ACK bits are kept set in every snapshot: the CSR is level-valued, and clearing a bit would withdraw done.
//  A PF reaching PEND during W_WAIT is not in the current snapshot. It is sent in the next write.
//  If i_written_valid and a timeout occur in the same cycle, i_written_valid wins.
//  o_wr_error latches on i_wr_error=1; cleared only by i_reset. o_timeout_error is sticky the same way.
//  Latency: quiesced PF to o_enable in 2 cycles when the write FSM is idle.
//  i_reset in mid-operation: all state is dropped and o_pf_reset goes to 0. Any PF whose FLR is still active
//   is re-tracked only on its next rising edge.
// STRUCTURE
//  flr_pkg: typedef enum pf_state_t {PF_IDLE,PF_RESET,PF_DRAIN,PF_PEND,PF_ACK}; typedef enum wr_state_t
//   {W_IDLE,W_ISSUE,W_WAIT}; localparam FLR_NUM_PF=4.
//  Sub-module flr_pf_tracker (one per PF, generate loop): edge detect, min-reset counter, per-PF FSM.
//   Outputs: state and o_pf_reset. Input: accept strobe.
//  The top level holds the write FSM, the snapshot register, the timeout/retry counters and the sticky errors.
// TESTING (bench drives the PCIe FLR levels and a responder model with a 3-cycle write latency)
//  1. Single PF: PF2 FLR rises, quiesced at cycle 20 -> o_pf_reset[2]=1 for >=16 cycles;
//     o_enable pulses once with done=4'b0100; PF2 FLR drops -> reset released, o_busy=0.
//  2. Concurrent: PF0 and PF3 quiesced on the same cycle -> one write, done=4'b1001.
//     PF1 pending during W_WAIT -> second write, done=4'b1011.
//  3. Timeout: responder silent, TIMEOUT_CYCLES=64, MAX_RETRY=3 -> 4 enables spaced 65 cycles apart;
//     then o_timeout_error=1 and PF stays PEND.
//  4. Abort: PF1 FLR drops in PF_RESET at cycle 5 -> o_pf_reset[1]=0 next cycle; no o_enable.
//  5. Error/reset: i_wr_error pulses -> o_wr_error=1 until i_reset. i_reset in W_WAIT -> all outputs 0;
//     FLR level still high does not restart.

Source files
------------

// File: rtl/flr_pkg.sv
// Shared types for the FLR sequencer: per-PF and write-side state encodings.
package flr_pkg;

   localparam int FLR_NUM_PF = 4;

   typedef enum logic [2:0] {
      PF_IDLE,
      PF_RESET,
      PF_DRAIN,
      PF_PEND,
      PF_ACK
   } pf_state_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_ISSUE,
      W_WAIT
   } wr_state_t;

endpackage

// File: rtl/flr_pf_tracker.sv
// One PF's FLR lifecycle: rising-edge detect, minimum reset hold, drain wait,
// then pending/acknowledged until the PCIe core drops the FLR level.
module flr_pf_tracker
   import flr_pkg::*;
#(
   parameter int MIN_RST_CYCLES = 16
) (
   input  logic      clk,
   input  logic      srst,
   input  logic      flr_active,
   input  logic      quiesced,
   input  logic      accept,
   output pf_state_t state,
   output logic      pf_reset
);

   localparam int            CW       = $clog2(MIN_RST_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(MIN_RST_CYCLES - 1);

   pf_state_t     state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          flr_prev_reg;
   logic          armed_reg;
   logic          pf_reset_reg;
   logic          flr_rise;

   // armed_reg masks the first cycle after reset so a level already high is not taken as an edge
   assign flr_rise = armed_reg && flr_active && !flr_prev_reg;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         PF_IDLE: begin
            if (flr_rise) begin
               state_next = PF_RESET;
               cnt_next   = '0;
            end
         end
         PF_RESET: begin
            if (!flr_active)              state_next = PF_IDLE;
            else if (cnt_reg == CNT_LAST) state_next = PF_DRAIN;
            else                          cnt_next   = cnt_reg + 1'b1;
         end
         PF_DRAIN: begin
            if (!flr_active)   state_next = PF_IDLE;
            else if (quiesced) state_next = PF_PEND;
         end
         PF_PEND: begin
            if (!flr_active)   state_next = PF_IDLE;
            else if (accept)   state_next = PF_ACK;
         end
         PF_ACK: begin
            if (!flr_active)   state_next = PF_IDLE;
         end
         default: state_next = PF_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_reg    <= PF_IDLE;
         cnt_reg      <= '0;
         flr_prev_reg <= 1'b0;
         armed_reg    <= 1'b0;
         pf_reset_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         flr_prev_reg <= flr_active;
         armed_reg    <= 1'b1;
         pf_reset_reg <= (state_next != PF_IDLE);
      end
   end

   assign state    = state_reg;
   assign pf_reset = pf_reset_reg;

endmodule

// File: rtl/flr_sequencer.sv
// FLR sequencer top: per-PF trackers plus the write FSM that snapshots the done
// vector, pulses the responder enable and handles timeout/retry and sticky errors.
module flr_sequencer
   import flr_pkg::*;
#(
   parameter int NUM_PF         = FLR_NUM_PF,
   parameter int MIN_RST_CYCLES = 16,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int MAX_RETRY      = 3
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [NUM_PF-1:0] i_flr_pf_active,
   input  logic [NUM_PF-1:0] i_pf_quiesced,
   output logic [NUM_PF-1:0] o_pf_reset,
   output logic              o_enable,
   output logic [NUM_PF-1:0] o_flr_pf_done,
   input  logic              i_written_valid,
   input  logic              i_wr_error,
   output logic              o_busy,
   output logic              o_wr_error,
   output logic              o_timeout_error
);

   localparam int            TW       = $clog2(TIMEOUT_CYCLES);
   localparam int            RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);

   pf_state_t         pf_state [NUM_PF];
   logic [NUM_PF-1:0] pend_vec, ack_vec, idle_vec, accept;

   generate
      for (genvar gi = 0; gi < NUM_PF; gi++) begin : g_pf
         flr_pf_tracker #(
            .MIN_RST_CYCLES (MIN_RST_CYCLES)
         ) u_tracker (
            .clk        (i_clk),
            .srst       (i_reset),
            .flr_active (i_flr_pf_active[gi]),
            .quiesced   (i_pf_quiesced[gi]),
            .accept     (accept[gi]),
            .state      (pf_state[gi]),
            .pf_reset   (o_pf_reset[gi])
         );
         assign pend_vec[gi] = (pf_state[gi] == PF_PEND);
         assign ack_vec[gi]  = (pf_state[gi] == PF_ACK);
         assign idle_vec[gi] = (pf_state[gi] == PF_IDLE);
      end
   endgenerate

   wr_state_t         wr_state_reg, wr_state_next;
   logic              enable_reg, enable_next;
   logic [NUM_PF-1:0] done_reg, done_next;
   logic [NUM_PF-1:0] snap_reg, snap_next;
   logic [TW-1:0]     timer_reg, timer_next;
   logic [RW-1:0]     retry_reg, retry_next;
   logic              timeout_error_reg, timeout_error_next;
   logic              wr_error_reg;

   // snap_reg holds only the PEND bits of the snapshot, so only those are promoted on completion.
   // Once the timeout error is raised, no further writes are started until reset.
   always_comb begin
      wr_state_next     = wr_state_reg;
      enable_next       = 1'b0;
      done_next         = done_reg;
      snap_next         = snap_reg;
      timer_next        = timer_reg;
      retry_next        = retry_reg;
      timeout_error_next = timeout_error_reg;
      accept            = '0;
      case (wr_state_reg)
         W_IDLE: begin
            if ((|pend_vec) && !timeout_error_reg) begin
               wr_state_next = W_ISSUE;
               enable_next   = 1'b1;
               done_next     = pend_vec | ack_vec;
               snap_next     = pend_vec;
            end
         end
         W_ISSUE: begin
            timer_next    = '0;
            wr_state_next = W_WAIT;
         end
         W_WAIT: begin
            if (i_written_valid) begin
               wr_state_next = W_IDLE;
               accept        = snap_reg;
               retry_next    = '0;
            end else if (timer_reg == TMR_LAST) begin
               if (retry_reg < RTY_MAX) begin
                  retry_next    = retry_reg + 1'b1;
                  enable_next   = 1'b1;
                  wr_state_next = W_ISSUE;
               end else begin
                  timeout_error_next = 1'b1;
                  retry_next         = '0;
                  wr_state_next      = W_IDLE;
               end
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         default: wr_state_next = W_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_state_reg      <= W_IDLE;
         enable_reg        <= 1'b0;
         done_reg          <= '0;
         snap_reg          <= '0;
         timer_reg         <= '0;
         retry_reg         <= '0;
         timeout_error_reg <= 1'b0;
         wr_error_reg      <= 1'b0;
      end else begin
         wr_state_reg      <= wr_state_next;
         enable_reg        <= enable_next;
         done_reg          <= done_next;
         snap_reg          <= snap_next;
         timer_reg         <= timer_next;
         retry_reg         <= retry_next;
         timeout_error_reg <= timeout_error_next;
         wr_error_reg      <= wr_error_reg | i_wr_error;
      end
   end

   assign o_enable        = enable_reg;
   assign o_flr_pf_done   = done_reg;
   assign o_busy          = (wr_state_reg != W_IDLE) || !(&idle_vec);
   assign o_wr_error      = wr_error_reg;
   assign o_timeout_error = timeout_error_reg;

endmodule

// File: tb/tb_flr_sequencer.sv
// Scenario bench for flr_sequencer: PCIe FLR level driver, 3-cycle responder model,
// and expected enable timing/done vectors derived from the FLR lifecycle rules.
module tb_flr_sequencer;

   localparam int MIN_RST = 16;
   localparam int TMO     = 64;
   localparam int RETRY   = 3;

   logic       clk = 1'b0;
   logic       srst;
   logic [3:0] flr, quiesced;
   logic       written_valid, wr_err;
   logic [3:0] pf_reset, done;
   logic       enable, busy, wr_error, timeout_error;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   bit         resp_silent = 1'b0;
   int         en_cyc[$];
   logic [3:0] en_done[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   flr_sequencer #(
      .NUM_PF         (4),
      .MIN_RST_CYCLES (MIN_RST),
      .TIMEOUT_CYCLES (TMO),
      .MAX_RETRY      (RETRY)
   ) dut (
      .i_clk           (clk),
      .i_reset         (srst),
      .i_flr_pf_active (flr),
      .i_pf_quiesced   (quiesced),
      .o_pf_reset      (pf_reset),
      .o_enable        (enable),
      .o_flr_pf_done   (done),
      .i_written_valid (written_valid),
      .i_wr_error      (wr_err),
      .o_busy          (busy),
      .o_wr_error      (wr_error),
      .o_timeout_error (timeout_error)
   );

   // record every enable pulse with its cycle and done vector
   always @(negedge clk) begin
      if (enable === 1'b1) begin
         en_cyc.push_back(cyc);
         en_done.push_back(done);
      end
   end

   // responder: written_valid 3 cycles after each enable unless silenced
   initial begin
      written_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (enable === 1'b1 && !resp_silent) begin
            repeat (3) @(posedge clk);
            #1 written_valid = 1'b1;
            @(posedge clk);
            #1 written_valid = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      en_cyc.delete();
      en_done.delete();
   endtask

   task automatic wait_enables(input int n, input int budget);
      for (int i = 0; i < budget && en_cyc.size() < n; i++) tick(1);
   endtask

   task automatic test_reset();
      srst = 1'b1; flr = 4'hF; quiesced = 4'h0; wr_err = 1'b0;
      tick(3);
      checks++;
      if ({pf_reset, enable, done, busy, wr_error, timeout_error} !== 11'b0) begin
         failures++;
         $display("FAIL reset_outputs: got %b expected 0", {pf_reset, enable, done, busy, wr_error, timeout_error});
      end
      srst = 1'b0;
      tick(4);
      checks++;
      if (pf_reset !== 4'h0) begin
         failures++;
         $display("FAIL reset_level_no_start: got pf_reset=%b expected 0000", pf_reset);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy: got %b expected 0", busy);
      end
      flr = 4'h0;
      tick(2);
   endtask

   task automatic test_single_pf();
      int q;
      clear_log();
      flr[2] = 1'b1;
      tick(1);
      checks++;
      if (pf_reset !== 4'b0100) begin
         failures++;
         $display("FAIL single_rst_on: got %b expected 0100", pf_reset);
      end
      tick(19);
      quiesced[2] = 1'b1;
      q = cyc;
      wait_enables(1, 40);
      tick(8);
      checks++;
      if (en_cyc.size() != 1) begin
         failures++;
         $display("FAIL single_enable_count: got %0d expected 1", en_cyc.size());
      end else begin
         checks++;
         if (en_cyc[0] !== q + 2) begin
            failures++;
            $display("FAIL single_enable_cycle: got %0d expected %0d", en_cyc[0], q + 2);
         end
         checks++;
         if (en_done[0] !== 4'b0100) begin
            failures++;
            $display("FAIL single_done: got %b expected 0100", en_done[0]);
         end
      end
      checks++;
      if (pf_reset !== 4'b0100) begin
         failures++;
         $display("FAIL single_rst_held: got %b expected 0100", pf_reset);
      end
      flr[2] = 1'b0; quiesced[2] = 1'b0;
      tick(1);
      checks++;
      if ({pf_reset, busy} !== 5'b0) begin
         failures++;
         $display("FAIL single_release: got pf_reset=%b busy=%b expected 0000/0", pf_reset, busy);
      end
      tick(2);
   endtask

   task automatic test_concurrent();
      int q;
      clear_log();
      flr = 4'b1011;
      tick(1);
      checks++;
      if (pf_reset !== 4'b1011) begin
         failures++;
         $display("FAIL conc_rst_on: got %b expected 1011", pf_reset);
      end
      tick(21);
      quiesced = 4'b1001;
      q = cyc;
      tick(2);
      quiesced[1] = 1'b1;
      wait_enables(2, 60);
      tick(8);
      checks++;
      if (en_cyc.size() != 2) begin
         failures++;
         $display("FAIL conc_enable_count: got %0d expected 2", en_cyc.size());
      end else begin
         checks++;
         if (en_cyc[0] !== q + 2) begin
            failures++;
            $display("FAIL conc_enable_cycle: got %0d expected %0d", en_cyc[0], q + 2);
         end
         checks++;
         if (en_done[0] !== 4'b1001) begin
            failures++;
            $display("FAIL conc_done_first: got %b expected 1001", en_done[0]);
         end
         checks++;
         if (en_done[1] !== 4'b1011) begin
            failures++;
            $display("FAIL conc_done_second: got %b expected 1011", en_done[1]);
         end
      end
      flr = 4'h0; quiesced = 4'h0;
      tick(1);
      checks++;
      if ({pf_reset, busy} !== 5'b0) begin
         failures++;
         $display("FAIL conc_release: got pf_reset=%b busy=%b expected 0000/0", pf_reset, busy);
      end
      tick(2);
   endtask

   task automatic test_random();
      logic [3:0] mask;
      int d, c0, exp_cyc;
      for (int it = 0; it < 8; it++) begin
         mask = 4'($urandom_range(1, 15));
         d    = int'($urandom_range(1, 30));
         clear_log();
         flr = mask;
         c0  = cyc;
         tick(1);
         checks++;
         if (pf_reset !== mask) begin
            failures++;
            $display("FAIL rand_rst_on[%0d]: got %b expected %b", it, pf_reset, mask);
         end
         if (d > 1) tick(d - 1);
         quiesced = mask;
         // quiescence only counts once the minimum reset hold has elapsed
         exp_cyc = c0 + ((d > MIN_RST + 1) ? d : MIN_RST + 1) + 2;
         wait_enables(1, 60);
         checks++;
         if (en_cyc.size() != 1) begin
            failures++;
            $display("FAIL rand_enable_count[%0d]: got %0d expected 1", it, en_cyc.size());
         end else begin
            checks++;
            if (en_cyc[0] !== exp_cyc || en_done[0] !== mask) begin
               failures++;
               $display("FAIL rand_enable[%0d]: got cyc=%0d done=%b expected cyc=%0d done=%b",
                        it, en_cyc[0], en_done[0], exp_cyc, mask);
            end
         end
         tick(int'($urandom_range(6, 12)));
         checks++;
         if (pf_reset !== mask) begin
            failures++;
            $display("FAIL rand_rst_held[%0d]: got %b expected %b", it, pf_reset, mask);
         end
         flr = 4'h0; quiesced = 4'h0;
         tick(1);
         checks++;
         if ({pf_reset, busy} !== 5'b0) begin
            failures++;
            $display("FAIL rand_release[%0d]: got pf_reset=%b busy=%b expected 0000/0", it, pf_reset, busy);
         end
         tick(2);
      end
   endtask

   task automatic test_abort();
      clear_log();
      flr[1] = 1'b1;
      tick(5);
      checks++;
      if (pf_reset !== 4'b0010) begin
         failures++;
         $display("FAIL abort_rst_on: got %b expected 0010", pf_reset);
      end
      quiesced[1] = 1'b1;
      flr[1] = 1'b0;
      tick(1);
      checks++;
      if (pf_reset !== 4'b0000) begin
         failures++;
         $display("FAIL abort_release: got %b expected 0000", pf_reset);
      end
      tick(30);
      checks++;
      if (en_cyc.size() != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_no_write: got enables=%0d busy=%b expected 0/0", en_cyc.size(), busy);
      end
      quiesced = 4'h0;
      tick(2);
   endtask

   task automatic test_error_reset();
      wr_err = 1'b1;
      tick(1);
      wr_err = 1'b0;
      checks++;
      if (wr_error !== 1'b1) begin
         failures++;
         $display("FAIL wr_error_set: got %b expected 1", wr_error);
      end
      tick(10);
      checks++;
      if (wr_error !== 1'b1) begin
         failures++;
         $display("FAIL wr_error_sticky: got %b expected 1", wr_error);
      end
      resp_silent = 1'b1;
      clear_log();
      flr[3] = 1'b1; quiesced[3] = 1'b1;
      wait_enables(1, 60);
      checks++;
      if (en_cyc.size() != 1) begin
         failures++;
         $display("FAIL midreset_enable: got %0d expected 1", en_cyc.size());
      end
      tick(5);
      srst = 1'b1;
      tick(1);
      checks++;
      if ({pf_reset, enable, done, busy, wr_error, timeout_error} !== 11'b0) begin
         failures++;
         $display("FAIL midreset_outputs: got %b expected 0", {pf_reset, enable, done, busy, wr_error, timeout_error});
      end
      srst = 1'b0;
      clear_log();
      tick(40);
      checks++;
      if (pf_reset !== 4'h0 || en_cyc.size() != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL midreset_no_restart: got pf_reset=%b enables=%0d busy=%b expected 0000/0/0",
                  pf_reset, en_cyc.size(), busy);
      end
      resp_silent = 1'b0;
      flr[3] = 1'b0;
      tick(2);
      flr[3] = 1'b1;
      tick(1);
      checks++;
      if (pf_reset !== 4'b1000) begin
         failures++;
         $display("FAIL fresh_edge_restart: got %b expected 1000", pf_reset);
      end
      wait_enables(1, 60);
      tick(8);
      flr = 4'h0; quiesced = 4'h0;
      tick(2);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL fresh_edge_complete: got busy=%b expected 0", busy);
      end
   endtask

   task automatic test_timeout();
      resp_silent = 1'b1;
      clear_log();
      flr[0] = 1'b1; quiesced[0] = 1'b1;
      for (int i = 0; i < 600 && timeout_error !== 1'b1; i++) tick(1);
      checks++;
      if (timeout_error !== 1'b1) begin
         failures++;
         $display("FAIL timeout_error_set: got %b expected 1", timeout_error);
      end
      checks++;
      if (en_cyc.size() != RETRY + 1) begin
         failures++;
         $display("FAIL timeout_enable_count: got %0d expected %0d", en_cyc.size(), RETRY + 1);
      end else begin
         for (int i = 1; i <= RETRY; i++) begin
            checks++;
            if (en_cyc[i] - en_cyc[i-1] !== TMO + 1) begin
               failures++;
               $display("FAIL timeout_spacing[%0d]: got %0d expected %0d", i, en_cyc[i] - en_cyc[i-1], TMO + 1);
            end
            checks++;
            if (en_done[i] !== en_done[0]) begin
               failures++;
               $display("FAIL timeout_same_snapshot[%0d]: got %b expected %b", i, en_done[i], en_done[0]);
            end
         end
      end
      checks++;
      if (pf_reset !== 4'b0001 || busy !== 1'b1) begin
         failures++;
         $display("FAIL timeout_pf_pending: got pf_reset=%b busy=%b expected 0001/1", pf_reset, busy);
      end
      flr = 4'h0; quiesced = 4'h0;
      resp_silent = 1'b0;
      srst = 1'b1;
      tick(2);
      srst = 1'b0;
      tick(1);
      checks++;
      if (timeout_error !== 1'b0) begin
         failures++;
         $display("FAIL timeout_cleared: got %b expected 0", timeout_error);
      end
   endtask

   initial begin
      srst = 1'b1; flr = 4'h0; quiesced = 4'h0; wr_err = 1'b0;
      test_reset();
      test_single_pf();
      test_concurrent();
      test_random();
      test_abort();
      test_error_reset();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
